// File: rtl/axi_burst_scheduler.sv
// -----------------------------------------------------------------------------
// axi_burst_scheduler
//
// Sequences AXI write and read bursts onto the bridge's single shared device
// port. A round-robin arbiter picks between the pending write burst (AW head
// with W data available) and the pending read burst (AR head). While a burst
// owns the port the block walks the per-beat byte address for FIXED/INCR/WRAP
// bursts, flags illegal bursts, produces the B/R response codes and issues
// the AW/AR FIFO pop strobes.
//
// Ports:
//   a_clk, a_reset          clock, synchronous active-high reset
//   aw_pending, aw_head_*   write request present and its AW head fields
//   w_beat, w_head_last     write beat consumed this cycle, its w_last flag
//   ar_pending, ar_head_*   read request present and its AR head fields
//   r_beat                  read beat handshake this cycle
//   b_ready                 write-response ready
//   wr_grant, rd_grant      which burst owns the device port
//   offset                  device word offset (byte address bits [7:2])
//   dev_wr_en               device write strobe (suppressed on decode error)
//   last_beat               current beat is the final beat of the burst
//   b_valid, b_resp         write response
//   r_resp                  read response for the current burst
//   aw_pop, ar_pop          single-cycle FIFO pop strobes
// -----------------------------------------------------------------------------
module axi_burst_scheduler #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        a_clk,
   input  logic        a_reset,
   input  logic        aw_pending,
   input  logic [31:0] aw_head_addr,
   input  logic [3:0]  aw_head_len,
   input  logic [2:0]  aw_head_size,
   input  logic [1:0]  aw_head_burst,
   input  logic        w_beat,
   input  logic        w_head_last,
   input  logic        ar_pending,
   input  logic [31:0] ar_head_addr,
   input  logic [3:0]  ar_head_len,
   input  logic [2:0]  ar_head_size,
   input  logic [1:0]  ar_head_burst,
   input  logic        r_beat,
   input  logic        b_ready,
   output logic        wr_grant,
   output logic        rd_grant,
   output logic [5:0]  offset,
   output logic        dev_wr_en,
   output logic        last_beat,
   output logic        b_valid,
   output logic [1:0]  b_resp,
   output logic [1:0]  r_resp,
   output logic        aw_pop,
   output logic        ar_pop
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR      = 2'd1,
      ST_WR_RESP = 2'd2,
      ST_RD      = 2'd3
   } state_t;

   localparam logic SERVED_READ  = 1'b0;
   localparam logic SERVED_WRITE = 1'b1;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Burst legality: oversize beat, reserved burst type, WRAP length that is
   // not a power of two, or start address not aligned to the beat size.
   function automatic logic burst_illegal(input logic [7:0] addr,
                                          input logic [3:0] len,
                                          input logic [2:0] size,
                                          input logic [1:0] burst);
      logic [7:0] align_mask;
      logic       wrap_len_bad;
      align_mask   = (8'd1 << size) - 8'd1;
      wrap_len_bad = (burst == BURST_WRAP) &&
                     !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
      return (size > 3'd2) || (burst == 2'b11) || wrap_len_bad ||
             ((addr & align_mask) != 8'd0);
   endfunction

   // Byte address of the next beat. The wrap span is computed wide and then
   // truncated, so oversized (already illegal) spans degrade to a full mask.
   function automatic logic [7:0] advance_addr(input logic [7:0] addr,
                                               input logic [3:0] len,
                                               input logic [2:0] size,
                                               input logic [1:0] burst);
      logic [7:0]  inc;
      logic [11:0] span;
      logic [7:0]  mask;
      logic [7:0]  sum;
      logic [7:0]  result;
      inc  = 8'd1 << size;
      span = ({8'd0, len} + 12'd1) << size;
      mask = span[7:0] - 8'd1;
      sum  = addr + inc;
      case (burst)
         BURST_FIXED: result = addr;
         BURST_INCR:  result = sum;
         BURST_WRAP:  result = (addr & ~mask) | (sum & mask);
         default:     result = addr;
      endcase
      return result;
   endfunction

   // DECERR outranks SLVERR.
   function automatic logic [1:0] resp_code(input logic dec_err, input logic slv_err);
      logic [1:0] code;
      if (dec_err) begin
         code = RESP_DECERR;
      end else if (slv_err) begin
         code = RESP_SLVERR;
      end else begin
         code = RESP_OKAY;
      end
      return code;
   endfunction

   state_t     state_r;
   state_t     state_s;
   logic       last_served_r;
   logic       last_served_s;
   logic [7:0] addr_r;
   logic [3:0] len_r;
   logic [2:0] size_r;
   logic [1:0] burst_r;
   logic [3:0] beat_cnt_r;
   logic       dec_err_r;
   logic       slv_err_r;

   logic       take_wr_s;
   logic       take_rd_s;
   logic       beat_s;
   logic       len_mismatch_s;
   logic       last_beat_s;
   logic       aw_pop_s;
   logic       ar_pop_s;
   logic       dev_wr_en_s;
   logic [1:0] resp_s;

   assign last_beat_s = ((state_r == ST_WR) || (state_r == ST_RD)) && (beat_cnt_r == len_r);
   assign resp_s      = resp_code(dec_err_r, slv_err_r);

   // Next-state, arbitration and per-cycle strobes
   always_comb begin
      state_s        = state_r;
      last_served_s  = last_served_r;
      take_wr_s      = 1'b0;
      take_rd_s      = 1'b0;
      beat_s         = 1'b0;
      len_mismatch_s = 1'b0;
      aw_pop_s       = 1'b0;
      ar_pop_s       = 1'b0;
      dev_wr_en_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // A tie goes to whichever side was not served last.
            if (aw_pending && (!ar_pending || (last_served_r == SERVED_READ))) begin
               take_wr_s = 1'b1;
               state_s   = ST_WR;
            end else if (ar_pending) begin
               take_rd_s = 1'b1;
               state_s   = ST_RD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WR: begin
            beat_s      = w_beat;
            dev_wr_en_s = w_beat & ~dec_err_r;
            // The burst ends on whichever comes first: the counted length or
            // w_last. Disagreement between the two is a length mismatch.
            if (w_beat && (last_beat_s || w_head_last)) begin
               len_mismatch_s = last_beat_s ^ w_head_last;
               state_s        = ST_WR_RESP;
            end else begin
               state_s = ST_WR;
            end
         end
         ST_WR_RESP: begin
            if (b_ready) begin
               aw_pop_s      = 1'b1;
               last_served_s = SERVED_WRITE;
               state_s       = ST_IDLE;
            end else begin
               state_s = ST_WR_RESP;
            end
         end
         ST_RD: begin
            beat_s = r_beat;
            if (r_beat && last_beat_s) begin
               ar_pop_s      = 1'b1;
               last_served_s = SERVED_READ;
               state_s       = ST_IDLE;
            end else begin
               state_s = ST_RD;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state and round-robin history
   always_ff @(posedge a_clk) begin
      if (a_reset) begin
         state_r       <= ST_IDLE;
         last_served_r <= SERVED_READ;
      end else begin
         state_r       <= state_s;
         last_served_r <= last_served_s;
      end
   end

   // Burst context: latched at grant, advanced on every accepted beat
   always_ff @(posedge a_clk) begin
      if (a_reset) begin
         addr_r     <= 8'd0;
         len_r      <= 4'd0;
         size_r     <= 3'd0;
         burst_r    <= 2'b00;
         beat_cnt_r <= 4'd0;
         dec_err_r  <= 1'b0;
         slv_err_r  <= 1'b0;
      end else if (take_wr_s) begin
         addr_r     <= aw_head_addr[7:0];
         len_r      <= aw_head_len;
         size_r     <= aw_head_size;
         burst_r    <= aw_head_burst;
         beat_cnt_r <= 4'd0;
         dec_err_r  <= (aw_head_addr[31:8] != BASE_ADDR[31:8]);
         slv_err_r  <= burst_illegal(aw_head_addr[7:0], aw_head_len, aw_head_size, aw_head_burst);
      end else if (take_rd_s) begin
         addr_r     <= ar_head_addr[7:0];
         len_r      <= ar_head_len;
         size_r     <= ar_head_size;
         burst_r    <= ar_head_burst;
         beat_cnt_r <= 4'd0;
         dec_err_r  <= (ar_head_addr[31:8] != BASE_ADDR[31:8]);
         slv_err_r  <= burst_illegal(ar_head_addr[7:0], ar_head_len, ar_head_size, ar_head_burst);
      end else if (beat_s) begin
         addr_r     <= advance_addr(addr_r, len_r, size_r, burst_r);
         beat_cnt_r <= beat_cnt_r + 4'd1;
         slv_err_r  <= slv_err_r | len_mismatch_s;
      end else begin
         addr_r     <= addr_r;
         beat_cnt_r <= beat_cnt_r;
      end
   end

   assign wr_grant  = (state_r == ST_WR) || (state_r == ST_WR_RESP);
   assign rd_grant  = (state_r == ST_RD);
   assign offset    = addr_r[7:2];
   assign dev_wr_en = dev_wr_en_s;
   assign last_beat = last_beat_s;
   assign b_valid   = (state_r == ST_WR_RESP);
   assign b_resp    = (state_r == ST_WR_RESP) ? resp_s : RESP_OKAY;
   assign r_resp    = (state_r == ST_RD) ? resp_s : RESP_OKAY;
   // A reset cycle never releases a FIFO entry.
   assign aw_pop    = aw_pop_s & ~a_reset;
   assign ar_pop    = ar_pop_s & ~a_reset;

endmodule

// File: tb/tb_axi_burst_scheduler.sv
// -----------------------------------------------------------------------------
// tb_axi_burst_scheduler
//
// Self-checking bench for axi_burst_scheduler. A transaction-level model keeps
// the owner of the port, the precomputed byte-address sequence of the current
// burst and its response code; a compare process checks every output against
// it on each falling edge. Directed scenarios pin the model with literal
// expectations, then randomized traffic (with occasional resets) follows.
// -----------------------------------------------------------------------------
module tb_axi_burst_scheduler;

   localparam logic [31:0] TB_BASE = 32'h0000_0000;

   localparam int PH_IDLE = 0;
   localparam int PH_WR   = 1;
   localparam int PH_RESP = 2;
   localparam int PH_RD   = 3;

   logic        a_clk;
   logic        a_reset;
   logic        aw_pending;
   logic [31:0] aw_head_addr;
   logic [3:0]  aw_head_len;
   logic [2:0]  aw_head_size;
   logic [1:0]  aw_head_burst;
   logic        w_beat;
   logic        w_head_last;
   logic        ar_pending;
   logic [31:0] ar_head_addr;
   logic [3:0]  ar_head_len;
   logic [2:0]  ar_head_size;
   logic [1:0]  ar_head_burst;
   logic        r_beat;
   logic        b_ready;
   logic        wr_grant;
   logic        rd_grant;
   logic [5:0]  offset;
   logic        dev_wr_en;
   logic        last_beat;
   logic        b_valid;
   logic [1:0]  b_resp;
   logic [1:0]  r_resp;
   logic        aw_pop;
   logic        ar_pop;

   int vectors   = 0;
   int miscompares = 0;

   axi_burst_scheduler #(.BASE_ADDR(TB_BASE)) dut (
      .a_clk(a_clk), .a_reset(a_reset),
      .aw_pending(aw_pending), .aw_head_addr(aw_head_addr), .aw_head_len(aw_head_len),
      .aw_head_size(aw_head_size), .aw_head_burst(aw_head_burst),
      .w_beat(w_beat), .w_head_last(w_head_last),
      .ar_pending(ar_pending), .ar_head_addr(ar_head_addr), .ar_head_len(ar_head_len),
      .ar_head_size(ar_head_size), .ar_head_burst(ar_head_burst),
      .r_beat(r_beat), .b_ready(b_ready),
      .wr_grant(wr_grant), .rd_grant(rd_grant), .offset(offset), .dev_wr_en(dev_wr_en),
      .last_beat(last_beat), .b_valid(b_valid), .b_resp(b_resp), .r_resp(r_resp),
      .aw_pop(aw_pop), .ar_pop(ar_pop)
   );

   initial a_clk = 1'b0;
   always #5 a_clk = ~a_clk;

   // ---------------- behavioural model ----------------
   int m_phase;
   int m_idx;
   int m_len;
   int m_cur;
   bit m_dec;
   bit m_slv;
   bit m_prefer_write;
   bit m_synced = 1'b0;
   int seq[17];

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Latch a new burst: error flags plus the whole byte-address walk.
   task automatic model_start(input logic [31:0] a, input logic [3:0] l,
                              input logic [2:0] s, input logic [1:0] b);
      int base;
      int inc;
      int mask;
      int li;
      li    = int'(l);
      base  = int'(a[7:0]);
      inc   = 1 << s;
      m_len = li;
      m_dec = (a[31:8] != TB_BASE[31:8]);
      m_slv = (s > 3'd2) || (b == 2'b11) ||
              ((b == 2'b10) && !(li == 1 || li == 3 || li == 7 || li == 15)) ||
              ((base % inc) != 0);
      mask  = ((li + 1) << s) - 1;
      seq[0] = base;
      for (int i = 1; i < 17; i++) begin
         case (b)
            2'b01:   seq[i] = (base + i * inc) % 256;
            2'b10:   seq[i] = ((seq[i-1] & ~mask) | ((seq[i-1] + inc) & mask)) & 255;
            default: seq[i] = base;
         endcase
      end
      m_idx = 0;
      m_cur = seq[0];
   endtask

   task automatic model_reset();
      m_phase = PH_IDLE;
      m_prefer_write = 1'b1;
      m_idx = 0;
      m_len = 0;
      m_cur = 0;
      m_dec = 1'b0;
      m_slv = 1'b0;
   endtask

   function automatic int code();
      return m_dec ? 3 : (m_slv ? 2 : 0);
   endfunction

   task automatic compare_outputs();
      bit in_burst;
      in_burst = (m_phase == PH_WR) || (m_phase == PH_RD);
      check("wr_grant", int'(wr_grant), int'((m_phase == PH_WR) || (m_phase == PH_RESP)));
      check("rd_grant", int'(rd_grant), int'(m_phase == PH_RD));
      check("offset", int'(offset), (m_cur >> 2) & 63);
      check("last_beat", int'(last_beat), int'(in_burst && (m_idx == m_len)));
      check("dev_wr_en", int'(dev_wr_en), int'((m_phase == PH_WR) && w_beat && !m_dec));
      check("b_valid", int'(b_valid), int'(m_phase == PH_RESP));
      check("b_resp", int'(b_resp), (m_phase == PH_RESP) ? code() : 0);
      check("r_resp", int'(r_resp), (m_phase == PH_RD) ? code() : 0);
      check("aw_pop", int'(aw_pop), int'(!a_reset && (m_phase == PH_RESP) && b_ready));
      check("ar_pop", int'(ar_pop), int'(!a_reset && (m_phase == PH_RD) && r_beat && (m_idx == m_len)));
   endtask

   task automatic model_advance();
      bit fin;
      if (a_reset) begin
         model_reset();
         m_synced = 1'b1;
      end else if (m_synced) begin
         case (m_phase)
            PH_IDLE: begin
               if (aw_pending && (!ar_pending || m_prefer_write)) begin
                  model_start(aw_head_addr, aw_head_len, aw_head_size, aw_head_burst);
                  m_phase = PH_WR;
               end else if (ar_pending) begin
                  model_start(ar_head_addr, ar_head_len, ar_head_size, ar_head_burst);
                  m_phase = PH_RD;
               end
            end
            PH_WR: begin
               if (w_beat) begin
                  fin = (m_idx == m_len);
                  if (fin || w_head_last) begin
                     if (fin != w_head_last) m_slv = 1'b1;
                     m_phase = PH_RESP;
                  end
                  m_idx++;
                  m_cur = seq[m_idx];
               end
            end
            PH_RESP: begin
               if (b_ready) begin
                  m_phase = PH_IDLE;
                  m_prefer_write = 1'b0;
               end
            end
            default: begin
               if (r_beat) begin
                  fin = (m_idx == m_len);
                  m_idx++;
                  m_cur = seq[m_idx];
                  if (fin) begin
                     m_phase = PH_IDLE;
                     m_prefer_write = 1'b1;
                  end
               end
            end
         endcase
      end
   endtask

   // Compare against the model, then move the model across the next edge.
   always @(negedge a_clk) begin
      if (m_synced) compare_outputs();
      model_advance();
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge a_clk);
      #2;
   endtask

   task automatic clear_inputs();
      aw_pending = 1'b0; aw_head_addr = 32'd0; aw_head_len = 4'd0;
      aw_head_size = 3'd0; aw_head_burst = 2'b00;
      w_beat = 1'b0; w_head_last = 1'b0;
      ar_pending = 1'b0; ar_head_addr = 32'd0; ar_head_len = 4'd0;
      ar_head_size = 3'd0; ar_head_burst = 2'b00;
      r_beat = 1'b0; b_ready = 1'b0;
   endtask

   task automatic rand_head(output logic [31:0] a, output logic [3:0] l,
                            output logic [2:0] s, output logic [1:0] b);
      logic [7:0] lo;
      s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      b = 2'($urandom_range(0, 3));
      if ((b == 2'b11) && ($urandom_range(0, 3) != 0)) b = 2'($urandom_range(0, 2));
      l = 4'($urandom_range(0, 15));
      if ((b == 2'b10) && ($urandom_range(0, 3) != 0)) l = 4'((2 << $urandom_range(0, 3)) - 1);
      lo = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) != 0) lo = lo & ~((8'd1 << s) - 8'd1);
      a[7:0]  = lo;
      a[31:8] = ($urandom_range(0, 7) == 0) ? 24'($urandom) : TB_BASE[31:8];
   endtask

   int wrap_off[4];
   int exp_wr[7];
   int exp_rd[7];

   initial begin
      clear_inputs();
      a_reset = 1'b1;
      repeat (3) tick();
      a_reset = 1'b0;

      // Single write 0x10, len 0, size 2, INCR
      aw_pending = 1'b1; aw_head_addr = 32'h0000_0010; aw_head_len = 4'd0;
      aw_head_size = 3'd2; aw_head_burst = 2'b01;
      @(negedge a_clk); check("t1_idle_grant", int'(wr_grant), 0);
      tick();
      aw_pending = 1'b0; w_beat = 1'b1; w_head_last = 1'b1;
      @(negedge a_clk);
      check("t1_wr_grant", int'(wr_grant), 1);
      check("t1_offset", int'(offset), 4);
      check("t1_dev_wr_en", int'(dev_wr_en), 1);
      tick();
      w_beat = 1'b0; w_head_last = 1'b0;
      @(negedge a_clk);
      check("t1_b_valid", int'(b_valid), 1);
      check("t1_b_resp", int'(b_resp), 0);
      check("t1_aw_pop_wait", int'(aw_pop), 0);
      tick();
      b_ready = 1'b1;
      @(negedge a_clk); check("t1_aw_pop", int'(aw_pop), 1);
      tick();
      b_ready = 1'b0;
      @(negedge a_clk); check("t1_released", int'(wr_grant), 0);

      // Read WRAP 0x38, len 3, size 2
      wrap_off = '{14, 15, 12, 13};
      ar_pending = 1'b1; ar_head_addr = 32'h0000_0038; ar_head_len = 4'd3;
      ar_head_size = 3'd2; ar_head_burst = 2'b10;
      tick();
      ar_pending = 1'b0; r_beat = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge a_clk);
         check("t2_offset", int'(offset), wrap_off[i]);
         check("t2_r_resp", int'(r_resp), 0);
         check("t2_ar_pop", int'(ar_pop), int'(i == 3));
         tick();
      end
      r_beat = 1'b0;
      @(negedge a_clk); check("t2_released", int'(rd_grant), 0);

      // Both pending from reset: W, gap, R, gap, W
      exp_wr = '{0, 1, 1, 0, 0, 0, 1};
      exp_rd = '{0, 0, 0, 0, 1, 0, 0};
      a_reset = 1'b1;
      tick();
      a_reset = 1'b0;
      aw_pending = 1'b1; aw_head_addr = 32'h0000_0020; aw_head_len = 4'd0;
      aw_head_size = 3'd2; aw_head_burst = 2'b01;
      ar_pending = 1'b1; ar_head_addr = 32'h0000_0040; ar_head_len = 4'd0;
      ar_head_size = 3'd2; ar_head_burst = 2'b01;
      w_beat = 1'b1; w_head_last = 1'b1; b_ready = 1'b1; r_beat = 1'b1;
      for (int c = 0; c < 7; c++) begin
         @(negedge a_clk);
         check("t3_wr_grant", int'(wr_grant), exp_wr[c]);
         check("t3_rd_grant", int'(rd_grant), exp_rd[c]);
         tick();
      end
      clear_inputs();
      b_ready = 1'b1;
      repeat (2) tick();
      b_ready = 1'b0;

      // Out-of-window write: beats counted, no device writes, DECERR
      aw_pending = 1'b1; aw_head_addr = 32'h0000_0100; aw_head_len = 4'd3;
      aw_head_size = 3'd2; aw_head_burst = 2'b01;
      tick();
      aw_pending = 1'b0; w_beat = 1'b1;
      for (int i = 0; i < 4; i++) begin
         w_head_last = (i == 3);
         @(negedge a_clk);
         check("t4_dev_wr_en", int'(dev_wr_en), 0);
         check("t4_last_beat", int'(last_beat), int'(i == 3));
         tick();
      end
      w_beat = 1'b0; w_head_last = 1'b0;
      @(negedge a_clk);
      check("t4_b_valid", int'(b_valid), 1);
      check("t4_b_resp", int'(b_resp), 3);
      tick();
      b_ready = 1'b1;
      @(negedge a_clk); check("t4_aw_pop", int'(aw_pop), 1);
      tick();
      b_ready = 1'b0;

      // Early w_last on beat 2 of len 3 -> SLVERR
      aw_pending = 1'b1; aw_head_addr = 32'h0000_0000; aw_head_len = 4'd3;
      aw_head_size = 3'd2; aw_head_burst = 2'b01;
      tick();
      aw_pending = 1'b0; w_beat = 1'b1; w_head_last = 1'b0;
      tick();
      w_head_last = 1'b1;
      tick();
      w_beat = 1'b0; w_head_last = 1'b0;
      @(negedge a_clk);
      check("t5_b_valid", int'(b_valid), 1);
      check("t5_b_resp", int'(b_resp), 2);
      tick();
      b_ready = 1'b1;
      tick();
      b_ready = 1'b0;

      // WRAP with len 2 -> SLVERR on read
      ar_pending = 1'b1; ar_head_addr = 32'h0000_0000; ar_head_len = 4'd2;
      ar_head_size = 3'd2; ar_head_burst = 2'b10;
      tick();
      ar_pending = 1'b0;
      @(negedge a_clk);
      check("t5_rd_grant", int'(rd_grant), 1);
      check("t5_r_resp", int'(r_resp), 2);
      tick();
      r_beat = 1'b1;
      repeat (3) tick();
      r_beat = 1'b0;
      tick();

      // Reset during beat 2 of a len-7 read
      ar_pending = 1'b1; ar_head_addr = 32'h0000_0000; ar_head_len = 4'd7;
      ar_head_size = 3'd2; ar_head_burst = 2'b01;
      tick();
      ar_pending = 1'b0; r_beat = 1'b1;
      @(negedge a_clk); check("t6_ar_pop_b1", int'(ar_pop), 0);
      tick();
      a_reset = 1'b1;
      @(negedge a_clk); check("t6_ar_pop_rst", int'(ar_pop), 0);
      tick();
      a_reset = 1'b0; r_beat = 1'b0;
      @(negedge a_clk);
      check("t6_rd_grant", int'(rd_grant), 0);
      check("t6_offset", int'(offset), 0);
      check("t6_last_beat", int'(last_beat), 0);
      check("t6_ar_pop", int'(ar_pop), 0);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         tick();
         a_reset    = ($urandom_range(0, 299) == 0);
         aw_pending = ($urandom_range(0, 2) != 0);
         ar_pending = ($urandom_range(0, 2) != 0);
         rand_head(aw_head_addr, aw_head_len, aw_head_size, aw_head_burst);
         rand_head(ar_head_addr, ar_head_len, ar_head_size, ar_head_burst);
         w_beat  = ($urandom_range(0, 9) < 6);
         r_beat  = ($urandom_range(0, 9) < 6);
         b_ready = ($urandom_range(0, 1) == 1);
         if ((m_phase == PH_WR) && ($urandom_range(0, 9) != 0))
            w_head_last = (m_idx == m_len);
         else
            w_head_last = ($urandom_range(0, 1) == 1);
      end
      tick();
      clear_inputs();
      a_reset = 1'b0;
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axi_burst_scheduler.md
# axi_burst_scheduler

- Sequences AXI write and read bursts onto the bridge's single shared device port.
- Arbitrates round-robin between the pending write burst (AW head plus W data) and the pending read burst (AR head).
- Generates the per-beat word offset for FIXED/INCR/WRAP bursts and checks burst legality.
- Produces the B/R response codes and FIFO pop strobes; sits between the bridge's AW/W/AR FIFOs and the device interface.

## Interface

Parameters:
- BASE_ADDR, 32'h0000_0000: device window base; only bits [31:8] are compared (256-byte window).

Ports:
- a_clk  in  1  clock; all state changes on rising edge.
- a_reset  in  1  synchronous, active-high reset.
- aw_pending  in  1  AW FIFO non-empty AND W FIFO non-empty.
- aw_head_addr / aw_head_len / aw_head_size / aw_head_burst  in  32/4/3/2  AW FIFO head fields.
- w_beat  in  1  W FIFO head consumed this cycle (write beat).
- w_head_last  in  1  w_last of the current W FIFO head.
- ar_pending  in  1  AR FIFO non-empty.
- ar_head_addr / ar_head_len / ar_head_size / ar_head_burst  in  32/4/3/2  AR FIFO head fields.
- r_beat  in  1  r_valid & r_ready this cycle.
- b_ready  in  1  AXI write-response ready.
- wr_grant  out  1  write burst owns the device port (WR or WR_RESP).
- rd_grant  out  1  read burst owns the device port (RD).
- offset  out  6  device word offset = byte_addr[7:2].
- dev_wr_en  out  1  = (state==WR) & w_beat & ~dec_err.
- last_beat  out  1  beat_cnt == latched len.
- b_valid  out  1  write response valid.
- b_resp  out  2  write response code.
- r_resp  out  2  read response code for the current burst.
- aw_pop  out  1  one-cycle pop strobe for the AW FIFO.
- ar_pop  out  1  one-cycle pop strobe for the AR FIFO.

## Operation

States:
- IDLE: no grant.
  - Only aw_pending → WR. Only ar_pending → RD.
  - Both pending → grant the side not in last_served.
  - On entry to WR/RD, latch head addr[7:0], len, size and burst; compute dec_err and slv_err; clear beat_cnt.
- WR:
  - Each w_beat advances beat_cnt and the address.
  - When w_beat & (last_beat | w_head_last) → WR_RESP.
  - Early w_last, or last_beat with w_head_last=0, sets slv_err (length mismatch).
- WR_RESP: b_valid=1 until b_ready. Handshake cycle: aw_pop=1, last_served←write, → IDLE.
- RD: each r_beat advances beat_cnt and the address. On r_beat & last_beat: ar_pop=1 that cycle, last_served←read, → IDLE.

Error rules (latched at burst start):
- dec_err = addr[31:8] != BASE_ADDR[31:8].
- slv_err is set if any of:
  - size > 2;
  - burst == 2'b11;
  - WRAP with len not in {1,3,7,15};
  - addr not aligned to (1<<size).
- Response code: DECERR (2'b11) takes priority over SLVERR (2'b10); otherwise OKAY (2'b00).
- dec_err suppresses dev_wr_en, but beats are still counted.

Address update per beat (8-bit byte address, inc = 1<<size):
- FIXED: unchanged.
- INCR: addr+inc, mod 256 (wraps silently).
- WRAP: mask = ((len+1)<<size)−1; addr = (addr & ~mask) | ((addr+inc) & mask).

## Timing

- Reset value of every output is 0; state = IDLE; last_served = read, so a write wins the first tie.
- Request seen in IDLE at cycle N → grant and first-beat offset valid at N+1.
- offset, last_beat and r_resp are registered state; they update the cycle after each beat.
- At least one IDLE cycle separates consecutive bursts.
- Last write beat at cycle M → b_valid=1 at M+1; b_resp stays stable while b_valid is held.
- aw_pop and ar_pop are single-cycle and never both high.
- w_beat outside WR and r_beat outside RD are ignored.
- Pending inputs are sampled only in IDLE.
- Reset asserted mid-burst → IDLE next cycle; all outputs 0; no pop issued.

## Test plan

- Single write, aw addr=0x10, len=0, size=2, INCR; one w_beat with w_last:
  - wr_grant at N+1, offset=4, dev_wr_en=1 on the beat;
  - b_valid next cycle with b_resp=00;
  - aw_pop=1 on the b_ready cycle.
- Read WRAP, addr=0x38, len=3, size=2:
  - offsets 14,15,12,13;
  - ar_pop together with the 4th r_beat;
  - r_resp=00.
- Both pending from reset:
  - write granted first, then read, then write again;
  - one IDLE cycle between bursts.
- Write addr=0x0000_0100 with BASE_ADDR=0:
  - all beats counted, dev_wr_en stays 0;
  - b_resp=11.
- Write len=3 with w_last on beat 2 → WR_RESP after beat 2, b_resp=10. Separately, WRAP with len=2 → r_resp=10.
- Reset pulse during beat 2 of a len=7 read → all outputs 0 next cycle; ar_pop never asserted.
